// File: rtl/rtc_capture_sequencer.sv
// rtl/rtc_capture_sequencer.sv - per-frame RTC field sweep into the display field register file
// Optional build macro RTC_ACK_TIMEOUT_EN: bounded ack wait with 8'hFF substitution and sticky err.
module rtc_capture_sequencer #(
    parameter int N_RELOJ     = 9,
    parameter int N_TEMP      = 13,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       temporizador,
    input  logic       rtc_ack,
    input  logic [7:0] rtc_dato,
    output logic       rtc_req,
    output logic [3:0] rtc_addr,
    output logic       wr_en,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_RELOJ = 4'(N_RELOJ);
    localparam logic [3:0] CNT_TEMP  = 4'(N_TEMP);

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] count_q, count_d;
    logic [7:0] data_q, data_d;
    logic       overrun_q, overrun_d;

`ifdef RTC_ACK_TIMEOUT_EN
    localparam logic [3:0] TMO_LIMIT = 4'(TIMEOUT_CYC);
    logic [3:0] tmo_q, tmo_d;
    logic [3:0] tmo_inc;
    logic       err_q, err_d;
`endif

    // State register and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= 4'd0;
            count_q   <= CNT_RELOJ;
            data_q    <= 8'd0;
            overrun_q <= 1'b0;
`ifdef RTC_ACK_TIMEOUT_EN
            tmo_q     <= 4'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
`ifdef RTC_ACK_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_q     <= err_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        count_d   = count_q;
        data_d    = data_q;
        overrun_d = frame_tick && (state_q != S_IDLE);
`ifdef RTC_ACK_TIMEOUT_EN
        tmo_d     = tmo_q;
        tmo_inc   = tmo_q + 4'd1;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    // Field count is frozen here; temporizador is not looked at again mid-sweep.
                    count_d = temporizador ? CNT_TEMP : CNT_RELOJ;
                    idx_d   = 4'd0;
                    state_d = S_REQ;
`ifdef RTC_ACK_TIMEOUT_EN
                    tmo_d   = 4'd0;
                    err_d   = 1'b0;
`endif
                end
            end
            S_REQ: begin
                if (rtc_ack) begin
                    data_d  = rtc_dato;
                    state_d = S_WRITE;
                end
`ifdef RTC_ACK_TIMEOUT_EN
                else if (tmo_inc == TMO_LIMIT) begin
                    data_d  = 8'hFF;
                    err_d   = 1'b1;
                    state_d = S_WRITE;
                end else begin
                    tmo_d = tmo_inc;
                end
`endif
            end
            S_WRITE: begin
                if (idx_q == count_q - 4'd1) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_REQ;
`ifdef RTC_ACK_TIMEOUT_EN
                    tmo_d   = 4'd0;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs; addresses and data are zeroed outside their strobe states
    always_comb begin
        rtc_req  = 1'b0;
        rtc_addr = 4'd0;
        wr_en    = 1'b0;
        wr_addr  = 4'd0;
        wr_data  = 8'd0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_REQ: begin
                rtc_req  = 1'b1;
                rtc_addr = idx_q;
                busy     = 1'b1;
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = idx_q;
                wr_data = data_q;
                busy    = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign overrun = overrun_q;

`ifdef RTC_ACK_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_capture_sequencer.sv
// tb/tb_rtc_capture_sequencer.sv - scoreboard bench for rtc_capture_sequencer
module tb_rtc_capture_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       temporizador;
    logic       rtc_ack;
    logic [7:0] rtc_dato;
    logic       rtc_req;
    logic [3:0] rtc_addr;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       overrun;
    logic       err;

    rtc_capture_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .temporizador (temporizador),
        .rtc_ack      (rtc_ack),
        .rtc_dato     (rtc_dato),
        .rtc_req      (rtc_req),
        .rtc_addr     (rtc_addr),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        int         cyc;
    } wr_t;

    wr_t wr_q[$];
    int  done_q[$];
    int  ovr_q[$];

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int t0 = 0;
    int mon_cyc;
    int done_cnt = 0;
    int req_cycles = 0;

    int          ack_delay = 0;
    logic [7:0]  ack_base = 8'h10;
    int          drop_addr = -1;
    bit          stray = 1'b0;
    int          wait_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // RTC model: acks after ack_delay waiting cycles, never for drop_addr
    initial begin
        rtc_ack  = 1'b0;
        rtc_dato = 8'h00;
        forever begin
            @(negedge clk);
            if (rtc_req) begin
                if (int'(rtc_addr) != drop_addr && wait_cnt >= ack_delay) begin
                    rtc_ack  = 1'b1;
                    rtc_dato = ack_base + 8'(rtc_addr);
                end else begin
                    rtc_ack  = 1'b0;
                    rtc_dato = 8'h5A;
                end
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                rtc_ack  = stray;
                rtc_dato = 8'hEE;
            end
        end
    end

    // Output monitor: pops the scoreboard on every strobe
    always @(negedge clk) begin
        mon_cyc = edge_cnt - t0;
        if (rtc_req) req_cycles++;
        if (wr_en) begin
            check("wr_extra", 32'(wr_q.size() != 0), 1);
            if (wr_q.size() != 0) begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.a));
                check("wr_data", 32'(wr_data), 32'(e.d));
                if (e.cyc >= 0) check("wr_cycle", mon_cyc, e.cyc);
            end
        end
        if (done) begin
            done_cnt++;
            check("done_extra", 32'(done_q.size() != 0), 1);
            if (done_q.size() != 0) begin
                int c;
                c = done_q.pop_front();
                if (c >= 0) check("done_cycle", mon_cyc, c);
            end
        end
        if (overrun) begin
            check("ovr_extra", 32'(ovr_q.size() != 0), 1);
            if (ovr_q.size() != 0) begin
                int c;
                c = ovr_q.pop_front();
                check("ovr_cycle", mon_cyc, c);
            end
        end
    end

    task automatic push_sweep(input int count, input logic [7:0] base, input bit timed, input int drop);
        for (int k = 0; k < count; k++) begin
            wr_t e;
            e.a   = 4'(k);
            e.d   = (k == drop) ? 8'hFF : base + 8'(k);
            e.cyc = timed ? 2 * k + 2 : -1;
            wr_q.push_back(e);
        end
        done_q.push_back(timed ? 2 * count + 1 : -1);
    endtask

    // Returns at the negedge of cycle 1 of the new sweep
    task automatic start_sweep(input bit temp);
        @(negedge clk);
        temporizador = temp;
        frame_tick   = 1'b1;
        t0           = edge_cnt;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic wait_sweep(input string tag);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
        check(tag, done_cnt - d0, 1);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 0);
    endtask

    function automatic logic [21:0] all_outs();
        return {rtc_req, rtc_addr, wr_en, wr_addr, wr_data, busy, done, overrun, err};
    endfunction

    initial begin
        reset        = 1'b1;
        frame_tick   = 1'b0;
        temporizador = 1'b0;
        #3;
        check("reset_outputs", 32'(all_outs()), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // Clock sweep, immediate ack; temporizador flip mid-sweep must not matter
        req_cycles = 0;
        push_sweep(9, 8'h10, 1'b1, -1);
        start_sweep(1'b0);
        check("req_cycle1", 32'(rtc_req), 1);
        check("addr_cycle1", 32'(rtc_addr), 0);
        check("busy_cycle1", 32'(busy), 1);
        repeat (3) @(negedge clk);
        temporizador = 1'b1;
        wait_sweep("sweep9_done");
        check("sweep9_req_cycles", req_cycles, 9);
`ifndef RTC_ACK_TIMEOUT_EN
        check("err_tied", 32'(err), 0);
`endif

        // frame_tick at cycle 5 -> overrun at cycle 6, sweep unaffected
        push_sweep(9, 8'h10, 1'b1, -1);
        ovr_q.push_back(6);
        start_sweep(1'b0);
        repeat (4) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        wait_sweep("overrun_sweep_done");

        // Timer sweep, ack after 3 waiting cycles, stray acks outside REQ
        req_cycles = 0;
        ack_delay  = 3;
        ack_base   = 8'h30;
        stray      = 1'b1;
        push_sweep(13, 8'h30, 1'b0, -1);
        start_sweep(1'b1);
        repeat (5) @(negedge clk);
        temporizador = 1'b0;
        wait_sweep("sweep13_done");
        check("sweep13_req_cycles", req_cycles, 52);
        stray     = 1'b0;
        ack_delay = 0;
        ack_base  = 8'h10;

        // Reset after field 4 is written: abort, then fresh sweep
        for (int k = 0; k < 5; k++) begin
            wr_t e;
            e.a   = 4'(k);
            e.d   = 8'h10 + 8'(k);
            e.cyc = 2 * k + 2;
            wr_q.push_back(e);
        end
        start_sweep(1'b0);
        for (int i = 0; i < 100 && wr_q.size() != 0; i++) @(negedge clk);
        check("reset_wait_writes", wr_q.size(), 0);
        begin
            int dc;
            dc = done_cnt;
            #2;
            reset = 1'b1;
            #1;
            check("reset_mid_outputs", 32'(all_outs()), 0);
            repeat (4) @(negedge clk);
            reset = 1'b0;
            repeat (3) @(negedge clk);
            check("reset_no_done", done_cnt - dc, 0);
        end
        push_sweep(9, 8'h10, 1'b1, -1);
        start_sweep(1'b0);
        check("restart_addr", 32'(rtc_addr), 0);
        wait_sweep("restart_done");

`ifdef RTC_ACK_TIMEOUT_EN
        req_cycles = 0;
        drop_addr  = 2;
        push_sweep(9, 8'h10, 1'b0, 2);
        start_sweep(1'b0);
        wait_sweep("timeout_sweep_done");
        check("timeout_req_cycles", req_cycles, 23);
        check("err_set", 32'(err), 1);
        drop_addr = -1;
        push_sweep(9, 8'h10, 1'b1, -1);
        start_sweep(1'b0);
        check("err_cleared", 32'(err), 0);
        wait_sweep("after_timeout_done");
        check("err_stays_clear", 32'(err), 0);
`endif

        repeat (3) @(negedge clk);
        check("wr_left", wr_q.size(), 0);
        check("done_left", done_q.size(), 0);
        check("ovr_left", ovr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_capture_sequencer.md
RTC_CAPTURE_SEQUENCER -- requirements
Module: rtc_capture_sequencer

Interface
REQ-001 Parameter N_RELOJ, default 9, SHALL set the field count swept when the timer is inactive.
REQ-002 Parameter N_TEMP, default 13, SHALL set the field count swept when the timer is active.
REQ-003 Parameter TIMEOUT_CYC, default 15, SHALL set the maximum number of REQ-state cycles spent waiting for ack (used only with RTC_ACK_TIMEOUT_EN).
REQ-004 Ports SHALL be:
clk  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-high
frame_tick  in  1  one-cycle pulse at end of visible frame (pixel 639,479)
temporizador  in  1  1 = timer active, sweep N_TEMP fields
rtc_ack  in  1  RTC data valid for current rtc_addr
rtc_dato  in  8  RTC field data (BCD), valid when rtc_ack=1
rtc_req  out  1  read request to RTC, held until ack
rtc_addr  out  4  field index being requested
wr_en  out  1  one-cycle write strobe to display field register file
wr_addr  out  4  field index written
wr_data  out  8  captured field data
busy  out  1  sweep in progress
done  out  1  one-cycle pulse, sweep complete
overrun  out  1  one-cycle pulse, frame_tick arrived while busy
err  out  1  sticky: at least one field timed out in the current/last sweep

Function
REQ-005 FSM states SHALL be IDLE, REQ, WRITE, DONE.
REQ-006 IDLE: on frame_tick=1, SHALL latch count = temporizador ? N_TEMP : N_RELOJ, set idx=0, clear err, go REQ; otherwise stay.
REQ-007 REQ: rtc_req=1, rtc_addr=idx; when rtc_ack=1 on a clock edge SHALL capture rtc_dato and go WRITE; otherwise stay.
REQ-008 WRITE: wr_en=1, wr_addr=idx, wr_data=captured value for exactly one cycle; if idx==count-1 go DONE, else idx=idx+1 and go REQ.
REQ-009 DONE: done=1 for one cycle, then IDLE.
REQ-010 busy SHALL be 1 in REQ, WRITE, DONE and 0 in IDLE.
REQ-011 Latency: frame_tick sampled at edge 0 with ack immediate each REQ cycle -> rtc_req high cycle 1, field k written cycle 2k+2, done cycle 2*count+1 (19 for 9 fields, 27 for 13).
REQ-012 rtc_ack outside REQ SHALL be ignored; rtc_dato SHALL be sampled only in REQ with rtc_ack=1.
REQ-013 frame_tick while busy SHALL not restart the sweep and SHALL pulse overrun for one cycle.
REQ-014 temporizador changes during a sweep SHALL have no effect until the next accepted frame_tick.
REQ-015 idx and count SHALL be 4-bit unsigned; idx SHALL never exceed count-1.
REQ-016 rtc_req SHALL deassert the cycle after ack is accepted (no back-to-back request without WRITE in between).

Reset
REQ-017 reset=1 SHALL asynchronously force state IDLE, idx=0, count=N_RELOJ, captured data 0, and all outputs 0.
REQ-018 reset mid-sweep SHALL abort with no further wr_en and no done pulse; the next frame_tick after release starts a fresh sweep from idx 0.

Configuration
REQ-019 With RTC_ACK_TIMEOUT_EN defined: a 4-bit counter SHALL count REQ cycles without ack; on reaching TIMEOUT_CYC the block SHALL capture 8'hFF, set err, and go WRITE; counter cleared on entering REQ.
REQ-020 Without RTC_ACK_TIMEOUT_EN: REQ SHALL wait indefinitely for ack and err SHALL be tied 0.

Verification
REQ-021 temporizador=0, frame_tick, ack every REQ cycle with rtc_dato=8'h10+idx -> 9 writes addr 0..8 data 10..18, done at cycle 19, busy 0 after.
REQ-022 temporizador=1, frame_tick, ack delayed 3 cycles per field -> 13 writes addr 0..12, rtc_req held each wait, done exactly once.
REQ-023 frame_tick pulsed at cycle 5 of a sweep -> overrun pulse at cycle 6, sweep continues unchanged, no restart.
REQ-024 reset asserted after write of field 4 -> outputs 0 immediately, no done; next frame_tick restarts at addr 0.
REQ-025 RTC_ACK_TIMEOUT_EN defined, no ack for field 2 -> after 15 REQ cycles wr_addr=2 wr_data=8'hFF, err=1, sweep completes; next frame_tick clears err.
